mycpu_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage replacing the single-register PC unit. It owns the PC and issues word reads to the synchronous instruction SRAM. Returned instructions are buffered with their PC in a small FIFO and handed to ID over a valid/ready handshake. A single redirect port (branch/jump target resolved in ID) flushes all fetched-but-undelivered work and restarts fetch at the target.

---
 rtl/mycpu_fetch_unit_if.sv | 27 ++
 rtl/mycpu_fetch_unit.sv | 120 ++++++++++++
 tb/tb_mycpu_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mycpu_fetch_unit_if.sv
// Fetch-stage bundle: redirect input, fetch-to-ID valid/ready handshake and
// the instruction SRAM request/response port.
interface mycpu_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  redirect_valid, redirect_target, out_ready, inst_sram_rdata,
    output out_valid, out_pc, out_inst,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output redirect_valid, redirect_target, out_ready, inst_sram_rdata,
    input  out_valid, out_pc, out_inst,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/mycpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency SRAM reads and
// buffers returned words with their PC in a small FIFO feeding ID.
module mycpu_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  mycpu_fetch_unit_if.master fbus
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] mem_pc_q   [QUEUE_DEPTH];
  logic [31:0] mem_pc_d   [QUEUE_DEPTH];
  logic [31:0] mem_inst_q [QUEUE_DEPTH];
  logic [31:0] mem_inst_d [QUEUE_DEPTH];

  logic          out_valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   occ_s;
  logic          unused_tgt_s;

  assign unused_tgt_s = ^fbus.redirect_target[1:0];

  // Handshake terms and the issue decision (occupancy counts a same-cycle pop).
  always_comb begin
    out_valid_s = (count_q != CW'(0)) && !rst;
    pop_s       = out_valid_s && fbus.out_ready;
    push_s      = pend_q && !fbus.redirect_valid;
    occ_s       = {1'b0, count_q} + {{CW{1'b0}}, pend_q} - {{CW{1'b0}}, pop_s};
    issue_s     = !rst && !fbus.redirect_valid && (occ_s < (CW+1)'(QUEUE_DEPTH));
  end

  // Next-state for PC, in-flight tracking and FIFO; redirect flushes everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    if (fbus.redirect_valid) begin
      fetch_pc_d = {fbus.redirect_target[31:2], 2'b00};
      head_d     = PW'(0);
      tail_d     = PW'(0);
      count_d    = CW'(0);
    end else begin
      if (issue_s) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        pend_d     = 1'b0;
      end
      if (push_s) begin
        mem_pc_d[tail_q]   = pend_pc_q;
        mem_inst_d[tail_q] = fbus.inst_sram_rdata;
        tail_d             = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      head_q     <= PW'(0);
      tail_q     <= PW'(0);
      count_q    <= CW'(0);
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

  assign fbus.out_valid       = out_valid_s;
  assign fbus.out_pc          = mem_pc_q[head_q];
  assign fbus.out_inst        = mem_inst_q[head_q];
  assign fbus.inst_sram_en    = issue_s;
  assign fbus.inst_sram_addr  = fetch_pc_q;
  assign fbus.inst_sram_wen   = 4'b0000;
  assign fbus.inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_mycpu_fetch_unit.sv
// Directed table-driven bench for mycpu_fetch_unit at depth 2, plus a
// hand-written stall/release sequence on a depth-4 instance.
module tb_mycpu_fetch_unit;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl[$];

  mycpu_fetch_unit_if bus2 ();
  mycpu_fetch_unit_if bus4 ();

  mycpu_fetch_unit #(.RESET_PC(32'hbfc00000), .QUEUE_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .fbus(bus2.master)
  );
  mycpu_fetch_unit #(.RESET_PC(32'hbfc00000), .QUEUE_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .fbus(bus4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (bus2.inst_sram_en) bus2.inst_sram_rdata <= inst_of(bus2.inst_sram_addr);
    if (bus4.inst_sram_en) bus4.inst_sram_rdata <= inst_of(bus4.inst_sram_addr);
  end

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt,
                     input logic en, input logic [31:0] addr, input logic v, input logic [31:0] pc);
    vec_t e;
    e.rst = r; e.rdy = rdy; e.rv = rv; e.tgt = tgt;
    e.en = en; e.addr = addr; e.v = v; e.pc = pc;
    tbl.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus2.out_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_target = 32'h0;
    bus4.out_ready = 1'b0; bus4.redirect_valid = 1'b0; bus4.redirect_target = 32'h0;
    bus2.inst_sram_rdata = 32'h0;
    bus4.inst_sram_rdata = 32'h0;

    // reset state
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // stall from reset: two entries fill, then issue stops
    add(0, 0, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(0, 0, 0, 0, 1, 32'hbfc00004, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 1, 32'hbfc00000);
    // release: no gap, no duplicate
    add(0, 1, 0, 0, 1, 32'hbfc00008, 1, 32'hbfc00000);
    add(0, 1, 0, 0, 1, 32'hbfc0000c, 1, 32'hbfc00004);
    add(0, 1, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00008);
    add(0, 1, 0, 0, 1, 32'hbfc00014, 1, 32'hbfc0000c);
    // redirect with one entry queued and one in flight; pop of bfc00010 completes
    add(0, 1, 1, 32'h80000010, 0, 0, 1, 32'hbfc00010);
    add(0, 1, 0, 0, 1, 32'h80000010, 0, 0);
    add(0, 1, 0, 0, 1, 32'h80000014, 0, 0);
    add(0, 1, 0, 0, 1, 32'h80000018, 1, 32'h80000010);
    // misaligned target
    add(0, 1, 1, 32'h80000013, 0, 0, 1, 32'h80000014);
    add(0, 1, 0, 0, 1, 32'h80000010, 0, 0);
    add(0, 1, 0, 0, 1, 32'h80000014, 0, 0);
    add(0, 1, 0, 0, 1, 32'h80000018, 1, 32'h80000010);
    // PC wrap at top of address space
    add(0, 1, 1, 32'hfffffffc, 0, 0, 1, 32'h80000014);
    add(0, 1, 0, 0, 1, 32'hfffffffc, 0, 0);
    add(0, 1, 0, 0, 1, 32'h00000000, 0, 0);
    add(0, 1, 0, 0, 1, 32'h00000004, 1, 32'hfffffffc);
    add(0, 1, 0, 0, 1, 32'h00000008, 1, 32'h00000000);
    // fill, then one-cycle reset mid-stream
    add(0, 0, 0, 0, 0, 0, 1, 32'h00000004);
    add(0, 0, 0, 0, 0, 0, 1, 32'h00000004);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'hbfc00000, 0, 0);
    add(0, 1, 0, 0, 1, 32'hbfc00004, 0, 0);
    add(0, 1, 0, 0, 1, 32'hbfc00008, 1, 32'hbfc00000);
    add(0, 1, 0, 0, 1, 32'hbfc0000c, 1, 32'hbfc00004);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst                  = tbl[i].rst;
      bus2.out_ready       = tbl[i].rdy;
      bus2.redirect_valid  = tbl[i].rv;
      bus2.redirect_target = tbl[i].tgt;
      #1;
      chk("en", i, {31'd0, bus2.inst_sram_en}, {31'd0, tbl[i].en});
      if (tbl[i].en) chk("addr", i, bus2.inst_sram_addr, tbl[i].addr);
      chk("valid", i, {31'd0, bus2.out_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk("pc", i, bus2.out_pc, tbl[i].pc);
        chk("inst", i, bus2.out_inst, inst_of(tbl[i].pc));
      end
      chk("wen", i, {28'd0, bus2.inst_sram_wen}, 32'd0);
      chk("wdata", i, bus2.inst_sram_wdata, 32'd0);
    end

    // depth-4 instance: reset, stall 10 cycles, then release
    @(negedge clk);
    rst = 1'b1;
    bus2.out_ready = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus4.out_ready = 1'b0;
    #1;
    chk("d4_rst_en", 100, {31'd0, bus4.inst_sram_en}, 32'd0);
    chk("d4_rst_valid", 100, {31'd0, bus4.out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus4.out_ready = 1'b0;
      #1;
      chk("d4_stall_en", 200 + i, {31'd0, bus4.inst_sram_en}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("d4_stall_addr", 200 + i, bus4.inst_sram_addr, 32'hbfc00000 + 32'(4 * i));
      chk("d4_stall_valid", 200 + i, {31'd0, bus4.out_valid}, (i < 2) ? 32'd0 : 32'd1);
      if (i >= 2) chk("d4_stall_pc", 200 + i, bus4.out_pc, 32'hbfc00000);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus4.out_ready = 1'b1;
      #1;
      chk("d4_rel_valid", 300 + i, {31'd0, bus4.out_valid}, 32'd1);
      chk("d4_rel_pc", 300 + i, bus4.out_pc, 32'hbfc00000 + 32'(4 * i));
      chk("d4_rel_inst", 300 + i, bus4.out_inst, inst_of(32'hbfc00000 + 32'(4 * i)));
      chk("d4_rel_en", 300 + i, {31'd0, bus4.inst_sram_en}, 32'd1);
      chk("d4_rel_addr", 300 + i, bus4.inst_sram_addr, 32'hbfc00010 + 32'(4 * i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
